ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32I core, between ID and MEM.
- Computes the ALU result, resolves branches and jumps, and issues the data-RAM request for loads and stores.
- Registers results into the EX→MEM pipeline using the same valid/ready/flush handshake as the other stages.
- The MEM stage then waits for the data-RAM read data belonging to the request issued here.

---
 rtl/core_pkg.sv | 37 +++
 rtl/ex_alu.sv | 39 +++
 rtl/ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_ex_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: widths, ALU operations,
// branch funct3 codes and the one-hot memory access size encoding.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // One-hot access size carried alongside loads and stores
    localparam int MEM_OP_WIDTH = 3;
    localparam int MEM_OP_BYTE  = 0;
    localparam int MEM_OP_HALF  = 1;
    localparam int MEM_OP_WORD  = 2;

    // ALU operations selected by ID
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASS2 = 4'd10
    } alu_op_e;

    // Branch funct3 codes
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU of the execute stage; one operation per cycle,
// results wrap modulo 2^XLEN. PASS2 forwards src2 (used for LUI).
module ex_alu
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [3:0]      opcode_i,
    output logic [XLEN-1:0] result_o
);

    alu_op_e    op;
    logic [4:0] shamt;

    assign op    = alu_op_e'(opcode_i);
    assign shamt = src2_i[4:0];

    // Select the result of the requested operation
    always_comb begin
        result_o = '0;
        case (op)
            ALU_ADD:   result_o = src1_i + src2_i;
            ALU_SUB:   result_o = src1_i - src2_i;
            ALU_SLL:   result_o = src1_i << shamt;
            ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
            ALU_XOR:   result_o = src1_i ^ src2_i;
            ALU_SRL:   result_o = src1_i >> shamt;
            ALU_SRA:   result_o = $unsigned($signed(src1_i) >>> shamt);
            ALU_OR:    result_o = src1_i | src2_i;
            ALU_AND:   result_o = src1_i & src2_i;
            ALU_PASS2: result_o = src2_i;
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution, data-RAM request issue and the
// EX->MEM pipeline register. A memory instruction may only leave EX once
// its RAM request has been accepted; req_sent remembers an accepted
// request while MEM is back-pressuring so it is never issued twice.
module ex_stage
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int REG_AW = core_pkg::REG_AW
) (
    input  logic                    clk,
    input  logic                    rst_b,

    output logic                    ex_pipe_ready,
    output logic                    ex_pipe_flush,
    input  logic                    ex_pipe_valid,
    input  logic [XLEN-1:0]         ex_pipe_pc,
    input  logic [XLEN-1:0]         ex_pipe_instruction,
    input  logic [3:0]              ex_pipe_alu_opcode,
    input  logic [XLEN-1:0]         ex_pipe_alu_src1,
    input  logic [XLEN-1:0]         ex_pipe_alu_src2,
    input  logic [XLEN-1:0]         ex_pipe_rs1_data,
    input  logic [XLEN-1:0]         ex_pipe_rs2_data,
    input  logic                    ex_pipe_branch,
    input  logic                    ex_pipe_jump,
    input  logic [2:0]              ex_pipe_branch_opcode,
    input  logic [XLEN-1:0]         ex_pipe_target,
    input  logic                    ex_pipe_mem_read,
    input  logic                    ex_pipe_mem_write,
    input  logic [MEM_OP_WIDTH-1:0] ex_pipe_mem_opcode,
    input  logic                    ex_pipe_unsign,
    input  logic                    ex_pipe_rd_write,
    input  logic [REG_AW-1:0]       ex_pipe_rd_addr,

    input  logic                    mem_pipe_ready,
    input  logic                    mem_pipe_flush,
    output logic                    mem_pipe_valid,
    output logic [XLEN-1:0]         mem_pipe_pc,
    output logic [XLEN-1:0]         mem_pipe_instruction,
    output logic                    mem_pipe_mem_read,
    output logic [MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode,
    output logic [1:0]              mem_pipe_mem_byte_addr,
    output logic                    mem_pipe_unsign,
    output logic                    mem_pipe_rd_write,
    output logic [REG_AW-1:0]       mem_pipe_rd_addr,
    output logic [XLEN-1:0]         mem_pipe_alu_result,

    output logic                    branch_take,
    output logic [XLEN-1:0]         branch_pc,

    output logic                    ex_rd_write,
    output logic [REG_AW-1:0]       ex_rd_addr,
    output logic [XLEN-1:0]         ex_rd_wdata,
    output logic                    ex_rd_is_load,

    output logic                    dram_req,
    output logic                    dram_we,
    output logic [XLEN-1:0]         dram_addr,
    output logic [3:0]              dram_wstrb,
    output logic [XLEN-1:0]         dram_wdata,
    input  logic                    dram_addr_ok
);

    localparam logic [0:0] REQ_IDLE = 1'b0;
    localparam logic [0:0] REQ_SENT = 1'b1;

    logic [0:0]      req_state_q, req_state_d;
    logic            req_sent;
    logic [XLEN-1:0] alu_result;
    logic            ex_valid, is_mem, ex_done, advance;
    logic            branch_cond;

    logic                    mem_valid_q;
    logic [XLEN-1:0]         mem_pc_q, mem_instr_q, mem_alu_result_q;
    logic                    mem_read_q, mem_unsign_q, mem_rd_write_q;
    logic [MEM_OP_WIDTH-1:0] mem_opcode_q;
    logic [1:0]              mem_byte_addr_q;
    logic [REG_AW-1:0]       mem_rd_addr_q;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .src1_i   (ex_pipe_alu_src1),
        .src2_i   (ex_pipe_alu_src2),
        .opcode_i (ex_pipe_alu_opcode),
        .result_o (alu_result)
    );

    assign req_sent      = (req_state_q == REQ_SENT);
    assign ex_valid      = ex_pipe_valid & ~mem_pipe_flush;
    assign is_mem        = ex_pipe_mem_read | ex_pipe_mem_write;
    assign ex_done       = ~is_mem | req_sent | (dram_req & dram_addr_ok);
    assign advance       = ex_done & mem_pipe_ready;
    assign ex_pipe_ready = ~ex_valid | advance;
    assign ex_pipe_flush = mem_pipe_flush;

    assign dram_req  = ex_valid & is_mem & ~req_sent;
    assign dram_we   = ex_pipe_mem_write;
    assign dram_addr = alu_result;

    assign branch_take = ex_valid & advance & (ex_pipe_jump | (ex_pipe_branch & branch_cond));
    assign branch_pc   = ex_pipe_target & {{(XLEN-1){1'b1}}, 1'b0};

    assign ex_rd_write   = ex_pipe_valid & ex_pipe_rd_write;
    assign ex_rd_addr    = ex_pipe_rd_addr;
    assign ex_rd_wdata   = alu_result;
    assign ex_rd_is_load = ex_pipe_valid & ex_pipe_mem_read;

    // Evaluate the branch condition selected by funct3
    always_comb begin
        branch_cond = 1'b0;
        case (ex_pipe_branch_opcode)
            BR_BEQ:  branch_cond = (ex_pipe_rs1_data == ex_pipe_rs2_data);
            BR_BNE:  branch_cond = (ex_pipe_rs1_data != ex_pipe_rs2_data);
            BR_BLT:  branch_cond = ($signed(ex_pipe_rs1_data) <  $signed(ex_pipe_rs2_data));
            BR_BGE:  branch_cond = ($signed(ex_pipe_rs1_data) >= $signed(ex_pipe_rs2_data));
            BR_BLTU: branch_cond = (ex_pipe_rs1_data <  ex_pipe_rs2_data);
            BR_BGEU: branch_cond = (ex_pipe_rs1_data >= ex_pipe_rs2_data);
            default: branch_cond = 1'b0;
        endcase
    end

    // Replicate store data across lanes and pick byte strobes from the low address bits
    always_comb begin
        dram_wdata = ex_pipe_rs2_data;
        dram_wstrb = 4'b0000;
        if (ex_pipe_mem_opcode[MEM_OP_BYTE]) begin
            dram_wdata = {4{ex_pipe_rs2_data[7:0]}};
            dram_wstrb = 4'b0001 << alu_result[1:0];
        end else if (ex_pipe_mem_opcode[MEM_OP_HALF]) begin
            dram_wdata = {2{ex_pipe_rs2_data[15:0]}};
            dram_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
        end else if (ex_pipe_mem_opcode[MEM_OP_WORD]) begin
            dram_wstrb = 4'b1111;
        end
        if (!ex_pipe_mem_write) begin
            dram_wstrb = 4'b0000;
        end
    end

    // Track whether the current instruction's RAM request is already accepted
    always_comb begin
        req_state_d = req_state_q;
        case (req_state_q)
            REQ_IDLE: if (dram_req & dram_addr_ok & ~mem_pipe_ready) req_state_d = REQ_SENT;
            REQ_SENT: if (mem_pipe_ready | mem_pipe_flush)          req_state_d = REQ_IDLE;
            default:  req_state_d = REQ_IDLE;
        endcase
    end

    // Control state: request tracker and EX->MEM valid bit
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            req_state_q <= REQ_IDLE;
            mem_valid_q <= 1'b0;
        end else begin
            req_state_q <= req_state_d;
            if (mem_pipe_ready) begin
                mem_valid_q <= ex_valid & ex_done;
            end
        end
    end

    // EX->MEM data fields, loaded whenever MEM accepts; not reset
    always_ff @(posedge clk) begin
        if (mem_pipe_ready) begin
            mem_pc_q         <= ex_pipe_pc;
            mem_instr_q      <= ex_pipe_instruction;
            mem_read_q       <= ex_pipe_mem_read;
            mem_opcode_q     <= ex_pipe_mem_opcode;
            mem_byte_addr_q  <= alu_result[1:0];
            mem_unsign_q     <= ex_pipe_unsign;
            mem_rd_write_q   <= ex_pipe_rd_write;
            mem_rd_addr_q    <= ex_pipe_rd_addr;
            mem_alu_result_q <= alu_result;
        end
    end

    assign mem_pipe_valid         = mem_valid_q;
    assign mem_pipe_pc            = mem_pc_q;
    assign mem_pipe_instruction   = mem_instr_q;
    assign mem_pipe_mem_read      = mem_read_q;
    assign mem_pipe_mem_opcode    = mem_opcode_q;
    assign mem_pipe_mem_byte_addr = mem_byte_addr_q;
    assign mem_pipe_unsign        = mem_unsign_q;
    assign mem_pipe_rd_write      = mem_rd_write_q;
    assign mem_pipe_rd_addr       = mem_rd_addr_q;
    assign mem_pipe_alu_result    = mem_alu_result_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: randomized ALU, store, branch traffic
// compared to an arithmetic reference model, plus directed stall, back-pressure,
// flush and asynchronous-reset scenarios.
module tb_ex_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        ex_pipe_ready, ex_pipe_flush, ex_pipe_valid;
    logic [31:0] ex_pipe_pc, ex_pipe_instruction;
    logic [3:0]  ex_pipe_alu_opcode;
    logic [31:0] ex_pipe_alu_src1, ex_pipe_alu_src2, ex_pipe_rs1_data, ex_pipe_rs2_data;
    logic        ex_pipe_branch, ex_pipe_jump;
    logic [2:0]  ex_pipe_branch_opcode;
    logic [31:0] ex_pipe_target;
    logic        ex_pipe_mem_read, ex_pipe_mem_write;
    logic [2:0]  ex_pipe_mem_opcode;
    logic        ex_pipe_unsign, ex_pipe_rd_write;
    logic [4:0]  ex_pipe_rd_addr;
    logic        mem_pipe_ready, mem_pipe_flush, mem_pipe_valid;
    logic [31:0] mem_pipe_pc, mem_pipe_instruction;
    logic        mem_pipe_mem_read;
    logic [2:0]  mem_pipe_mem_opcode;
    logic [1:0]  mem_pipe_mem_byte_addr;
    logic        mem_pipe_unsign, mem_pipe_rd_write;
    logic [4:0]  mem_pipe_rd_addr;
    logic [31:0] mem_pipe_alu_result;
    logic        branch_take;
    logic [31:0] branch_pc;
    logic        ex_rd_write;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_rd_wdata;
    logic        ex_rd_is_load, dram_req, dram_we;
    logic [31:0] dram_addr, dram_wdata;
    logic [3:0]  dram_wstrb;
    logic        dram_addr_ok;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst_b(rst_b),
        .ex_pipe_ready(ex_pipe_ready), .ex_pipe_flush(ex_pipe_flush),
        .ex_pipe_valid(ex_pipe_valid), .ex_pipe_pc(ex_pipe_pc),
        .ex_pipe_instruction(ex_pipe_instruction), .ex_pipe_alu_opcode(ex_pipe_alu_opcode),
        .ex_pipe_alu_src1(ex_pipe_alu_src1), .ex_pipe_alu_src2(ex_pipe_alu_src2),
        .ex_pipe_rs1_data(ex_pipe_rs1_data), .ex_pipe_rs2_data(ex_pipe_rs2_data),
        .ex_pipe_branch(ex_pipe_branch), .ex_pipe_jump(ex_pipe_jump),
        .ex_pipe_branch_opcode(ex_pipe_branch_opcode), .ex_pipe_target(ex_pipe_target),
        .ex_pipe_mem_read(ex_pipe_mem_read), .ex_pipe_mem_write(ex_pipe_mem_write),
        .ex_pipe_mem_opcode(ex_pipe_mem_opcode), .ex_pipe_unsign(ex_pipe_unsign),
        .ex_pipe_rd_write(ex_pipe_rd_write), .ex_pipe_rd_addr(ex_pipe_rd_addr),
        .mem_pipe_ready(mem_pipe_ready), .mem_pipe_flush(mem_pipe_flush),
        .mem_pipe_valid(mem_pipe_valid), .mem_pipe_pc(mem_pipe_pc),
        .mem_pipe_instruction(mem_pipe_instruction), .mem_pipe_mem_read(mem_pipe_mem_read),
        .mem_pipe_mem_opcode(mem_pipe_mem_opcode), .mem_pipe_mem_byte_addr(mem_pipe_mem_byte_addr),
        .mem_pipe_unsign(mem_pipe_unsign), .mem_pipe_rd_write(mem_pipe_rd_write),
        .mem_pipe_rd_addr(mem_pipe_rd_addr), .mem_pipe_alu_result(mem_pipe_alu_result),
        .branch_take(branch_take), .branch_pc(branch_pc),
        .ex_rd_write(ex_rd_write), .ex_rd_addr(ex_rd_addr),
        .ex_rd_wdata(ex_rd_wdata), .ex_rd_is_load(ex_rd_is_load),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_wstrb(dram_wstrb), .dram_wdata(dram_wdata), .dram_addr_ok(dram_addr_ok)
    );

    // Reference ALU written from the instruction semantics
    function automatic logic [31:0] model_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int s;
        logic [31:0] r;
        s = int'(b % 32);
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a + (~b + 32'd1);
            ALU_SLL:   return a * (32'd1 << s);
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:   return a ^ b;
            ALU_SRL:   return a / (32'd1 << s);
            ALU_SRA: begin
                r = a / (32'd1 << s);
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
                return r;
            end
            ALU_OR:    return a | b;
            ALU_AND:   return a & b;
            ALU_PASS2: return b;
            default:   return 32'd0;
        endcase
    endfunction

    // Reference branch decision
    function automatic logic model_cond(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_idle();
        ex_pipe_valid = 0; ex_pipe_pc = 0; ex_pipe_instruction = 0;
        ex_pipe_alu_opcode = ALU_ADD; ex_pipe_alu_src1 = 0; ex_pipe_alu_src2 = 0;
        ex_pipe_rs1_data = 0; ex_pipe_rs2_data = 0; ex_pipe_branch = 0; ex_pipe_jump = 0;
        ex_pipe_branch_opcode = 0; ex_pipe_target = 0; ex_pipe_mem_read = 0;
        ex_pipe_mem_write = 0; ex_pipe_mem_opcode = 0; ex_pipe_unsign = 0;
        ex_pipe_rd_write = 0; ex_pipe_rd_addr = 0;
        mem_pipe_ready = 1; mem_pipe_flush = 0; dram_addr_ok = 0;
    endtask

    task automatic test_reset();
        rst_b = 0;
        set_idle();
        #2;
        checks++; if (mem_pipe_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mem_pipe_valid); end
        checks++; if (ex_pipe_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ex_pipe_ready); end
        checks++; if (dram_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", dram_req); end
        @(negedge clk); rst_b = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        logic [3:0]  op;
        logic [31:0] a, b, pc, exp;
        logic [4:0]  rd;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 10)); a = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (i == 0) begin op = ALU_ADD; a = 5; b = 7; end
            rd = 5'($urandom_range(1, 31)); pc = $urandom;
            ex_pipe_valid = 1; ex_pipe_alu_opcode = op; ex_pipe_alu_src1 = a; ex_pipe_alu_src2 = b;
            ex_pipe_rd_write = 1; ex_pipe_rd_addr = rd; ex_pipe_pc = pc; mem_pipe_ready = 1;
            exp = model_alu(op, a, b);
            @(negedge clk);
            checks++; if (ex_rd_wdata !== exp) begin errors++; $display("FAIL alu_fwd op=%0d a=%h b=%h got %h want %h", op, a, b, ex_rd_wdata, exp); end
            checks++; if (ex_pipe_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b want 1", ex_pipe_ready); end
            checks++; if (ex_rd_write !== 1'b1 || ex_rd_addr !== rd) begin errors++; $display("FAIL alu_rd got %b/%0d want 1/%0d", ex_rd_write, ex_rd_addr, rd); end
            @(posedge clk); #1;
            checks++; if (mem_pipe_valid !== 1'b1) begin errors++; $display("FAIL alu_mvalid got %b want 1", mem_pipe_valid); end
            checks++; if (mem_pipe_alu_result !== exp) begin errors++; $display("FAIL alu_result op=%0d got %h want %h", op, mem_pipe_alu_result, exp); end
            checks++; if (mem_pipe_rd_addr !== rd || mem_pipe_pc !== pc) begin errors++; $display("FAIL alu_fields got %0d/%h want %0d/%h", mem_pipe_rd_addr, mem_pipe_pc, rd, pc); end
        end
        set_idle();
        @(posedge clk); #1;
        checks++; if (mem_pipe_valid !== 1'b0) begin errors++; $display("FAIL alu_bubble got %b want 0", mem_pipe_valid); end
    endtask

    task automatic test_store();
        logic [31:0] base, off, addr, rs2, expwd;
        logic [3:0]  expst;
        int sz;
        for (int i = 0; i < 10; i++) begin
            sz = $urandom_range(0, 2); base = $urandom & 32'hFFFF_FFF0;
            off = 32'($urandom_range(0, 15)); rs2 = $urandom;
            if (i == 0) begin sz = 0; base = 32'h1000; off = 2; rs2 = 32'h0000_00AB; end
            addr = base + off;
            if (sz == 0) begin expwd = {24'd0, rs2[7:0]} * 32'h0101_0101; expst = 4'd1 << addr[1:0]; end
            else if (sz == 1) begin expwd = {16'd0, rs2[15:0]} * 32'h0001_0001; expst = addr[1] ? 4'hC : 4'h3; end
            else begin expwd = rs2; expst = 4'hF; end
            ex_pipe_valid = 1; ex_pipe_mem_write = 1; ex_pipe_mem_opcode = 3'(1 << sz);
            ex_pipe_alu_opcode = ALU_ADD; ex_pipe_alu_src1 = base; ex_pipe_alu_src2 = off;
            ex_pipe_rs2_data = rs2; dram_addr_ok = 1; mem_pipe_ready = 1;
            @(negedge clk);
            checks++; if (dram_req !== 1'b1 || dram_we !== 1'b1) begin errors++; $display("FAIL st_req got req=%b we=%b want 1/1", dram_req, dram_we); end
            checks++; if (dram_addr !== addr) begin errors++; $display("FAIL st_addr got %h want %h", dram_addr, addr); end
            checks++; if (dram_wdata !== expwd) begin errors++; $display("FAIL st_wdata sz=%0d got %h want %h", sz, dram_wdata, expwd); end
            checks++; if (dram_wstrb !== expst) begin errors++; $display("FAIL st_wstrb sz=%0d addr=%h got %b want %b", sz, addr, dram_wstrb, expst); end
            checks++; if (ex_pipe_ready !== 1'b1) begin errors++; $display("FAIL st_ready got %b want 1", ex_pipe_ready); end
            @(posedge clk); #1;
            checks++; if (mem_pipe_valid !== 1'b1 || mem_pipe_mem_byte_addr !== addr[1:0]) begin errors++; $display("FAIL st_adv got %b/%0d want 1/%0d", mem_pipe_valid, mem_pipe_mem_byte_addr, addr[1:0]); end
        end
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_load_stall();
        ex_pipe_valid = 1; ex_pipe_mem_read = 1; ex_pipe_mem_opcode = 3'b100;
        ex_pipe_alu_opcode = ALU_ADD; ex_pipe_alu_src1 = 32'h1FF0; ex_pipe_alu_src2 = 32'h10;
        ex_pipe_rd_write = 1; ex_pipe_rd_addr = 5'd9; mem_pipe_ready = 1;
        for (int c = 0; c < 4; c++) begin
            dram_addr_ok = (c == 3);
            @(negedge clk);
            checks++; if (dram_req !== 1'b1 || dram_addr !== 32'h2000) begin errors++; $display("FAIL lw_req c=%0d got %b/%h want 1/00002000", c, dram_req, dram_addr); end
            checks++; if (ex_pipe_ready !== (c == 3)) begin errors++; $display("FAIL lw_ready c=%0d got %b want %b", c, ex_pipe_ready, (c == 3)); end
            checks++; if (dram_wstrb !== 4'b0 || ex_rd_is_load !== 1'b1) begin errors++; $display("FAIL lw_misc got %b/%b want 0000/1", dram_wstrb, ex_rd_is_load); end
            @(posedge clk); #1;
            checks++; if (mem_pipe_valid !== (c == 3)) begin errors++; $display("FAIL lw_mvalid c=%0d got %b want %b", c, mem_pipe_valid, (c == 3)); end
        end
        checks++; if (mem_pipe_mem_byte_addr !== 2'd0 || mem_pipe_mem_read !== 1'b1) begin errors++; $display("FAIL lw_fields got %0d/%b want 0/1", mem_pipe_mem_byte_addr, mem_pipe_mem_read); end
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int reqs = 0;
        ex_pipe_valid = 1; ex_pipe_mem_read = 1; ex_pipe_unsign = 1; ex_pipe_mem_opcode = 3'b010;
        ex_pipe_alu_opcode = ALU_ADD; ex_pipe_alu_src1 = 32'h3000; ex_pipe_alu_src2 = 32'h6;
        dram_addr_ok = 1;
        for (int c = 0; c < 3; c++) begin
            mem_pipe_ready = (c == 2);
            @(negedge clk);
            if (dram_req) reqs++;
            checks++; if (dram_req !== (c == 0)) begin errors++; $display("FAIL lh_req c=%0d got %b want %b", c, dram_req, (c == 0)); end
            checks++; if (ex_pipe_ready !== (c == 2)) begin errors++; $display("FAIL lh_ready c=%0d got %b want %b", c, ex_pipe_ready, (c == 2)); end
            @(posedge clk); #1;
            checks++; if (mem_pipe_valid !== (c == 2)) begin errors++; $display("FAIL lh_mvalid c=%0d got %b want %b", c, mem_pipe_valid, (c == 2)); end
        end
        checks++; if (reqs != 1) begin errors++; $display("FAIL lh_count got %0d want 1", reqs); end
        checks++; if (mem_pipe_mem_byte_addr !== 2'd2 || mem_pipe_unsign !== 1'b1 || mem_pipe_mem_opcode !== 3'b010) begin
            errors++; $display("FAIL lh_fields got %0d/%b/%b want 2/1/010", mem_pipe_mem_byte_addr, mem_pipe_unsign, mem_pipe_mem_opcode); end
        // A following load must issue again now that the tracker is idle
        ex_pipe_alu_src2 = 32'h8; dram_addr_ok = 0;
        @(negedge clk);
        checks++; if (dram_req !== 1'b1) begin errors++; $display("FAIL lh_next_req got %b want 1", dram_req); end
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        ex_pipe_valid = 1; ex_pipe_mem_read = 1; ex_pipe_mem_opcode = 3'b100;
        ex_pipe_alu_src1 = 32'h40; mem_pipe_flush = 1; dram_addr_ok = 1;
        @(negedge clk);
        checks++; if (dram_req !== 1'b0 || ex_pipe_flush !== 1'b1) begin errors++; $display("FAIL fl_req got %b/%b want 0/1", dram_req, ex_pipe_flush); end
        checks++; if (ex_pipe_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got %b want 1", ex_pipe_ready); end
        @(posedge clk); #1;
        checks++; if (mem_pipe_valid !== 1'b0) begin errors++; $display("FAIL fl_mvalid got %b want 0", mem_pipe_valid); end
        // Accepted request abandoned by a flush while MEM stalls
        mem_pipe_flush = 0; mem_pipe_ready = 0;
        @(posedge clk); #1;
        mem_pipe_flush = 1;
        @(negedge clk);
        checks++; if (dram_req !== 1'b0) begin errors++; $display("FAIL fl_sent_req got %b want 0", dram_req); end
        @(posedge clk); #1;
        mem_pipe_flush = 0; ex_pipe_alu_src1 = 32'h80;
        @(negedge clk);
        checks++; if (dram_req !== 1'b1) begin errors++; $display("FAIL fl_reissue got %b want 1", dram_req); end
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_branch();
        logic [2:0]  f3s [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [2:0]  f3;
        logic [31:0] a, b, tgt;
        logic        exp;
        for (int i = 0; i < 20; i++) begin
            f3 = f3s[$urandom_range(0, 5)]; a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            tgt = $urandom;
            if (i == 0) begin f3 = 3'b100; a = 32'hFFFF_FFFF; b = 1; tgt = 32'h104; end
            if (i == 1) begin f3 = 3'b110; a = 32'hFFFF_FFFF; b = 1; tgt = 32'h104; end
            exp = model_cond(f3, a, b);
            ex_pipe_valid = 1; ex_pipe_branch = 1; ex_pipe_branch_opcode = f3;
            ex_pipe_rs1_data = a; ex_pipe_rs2_data = b; ex_pipe_target = tgt; mem_pipe_ready = 1;
            @(negedge clk);
            checks++; if (branch_take !== exp) begin errors++; $display("FAIL br_take f3=%0d a=%h b=%h got %b want %b", f3, a, b, branch_take, exp); end
            checks++; if (branch_pc !== {tgt[31:1], 1'b0}) begin errors++; $display("FAIL br_pc got %h want %h", branch_pc, {tgt[31:1], 1'b0}); end
            @(posedge clk); #1;
        end
        set_idle();
        @(negedge clk);
        checks++; if (branch_take !== 1'b0) begin errors++; $display("FAIL br_once got %b want 0", branch_take); end
        @(posedge clk); #1;
        // Jump: link address from the ALU, redirect regardless of compare
        ex_pipe_valid = 1; ex_pipe_jump = 1; ex_pipe_alu_src1 = 32'h200; ex_pipe_alu_src2 = 4;
        ex_pipe_target = 32'h0000_0333;
        @(negedge clk);
        checks++; if (branch_take !== 1'b1 || branch_pc !== 32'h332 || ex_rd_wdata !== 32'h204) begin
            errors++; $display("FAIL jal got %b/%h/%h want 1/00000332/00000204", branch_take, branch_pc, ex_rd_wdata); end
        @(posedge clk); #1;
        // Taken branch held while MEM stalls, redirects only on advance
        ex_pipe_jump = 0; ex_pipe_branch = 1; ex_pipe_branch_opcode = 3'b000;
        ex_pipe_rs1_data = 7; ex_pipe_rs2_data = 7; mem_pipe_ready = 0;
        @(negedge clk);
        checks++; if (branch_take !== 1'b0 || ex_pipe_ready !== 1'b0) begin errors++; $display("FAIL br_stall got %b/%b want 0/0", branch_take, ex_pipe_ready); end
        @(posedge clk); #1;
        mem_pipe_ready = 1;
        @(negedge clk);
        checks++; if (branch_take !== 1'b1) begin errors++; $display("FAIL br_release got %b want 1", branch_take); end
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stall();
        ex_pipe_valid = 1; ex_pipe_alu_src1 = 1; ex_pipe_alu_src2 = 2;
        @(posedge clk); #1;
        ex_pipe_mem_read = 1; ex_pipe_mem_opcode = 3'b010; ex_pipe_alu_src1 = 32'h500;
        mem_pipe_ready = 0; dram_addr_ok = 1;
        @(posedge clk); #1;
        checks++; if (dram_req !== 1'b0 || mem_pipe_valid !== 1'b1) begin errors++; $display("FAIL rs_pre got %b/%b want 0/1", dram_req, mem_pipe_valid); end
        rst_b = 0;
        #1;
        checks++; if (mem_pipe_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b want 0", mem_pipe_valid); end
        checks++; if (dram_req !== 1'b1) begin errors++; $display("FAIL rs_sent got req=%b want 1", dram_req); end
        #1 rst_b = 1;
        set_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load_stall();
        test_backpressure();
        test_flush();
        test_branch();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
